// File: rtl/program_counter.sv
// 65C02 program counter: 16-bit PC with increment, byte loads and relative branches
// that take an extra falling-edge cycle to fix up PCH when the branch crosses a page.
module program_counter #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INC,
    input  logic        LDL,
    input  logic        LDH,
    input  logic        BR,
    input  logic [7:0]  DIN,
    input  logic        OEL,
    input  logic        OEH,
    output logic [15:0] ADDR,
    output logic [7:0]  DOUT,
    output logic        BUSY,
    output logic        PAGEX
);

    typedef enum logic {IDLE, FIX} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pcl_q, pcl_d;
    logic [7:0]  pch_q, pch_d;
    logic [7:0]  adj_q, adj_d;
    logic [8:0]  br_sum;
    logic        br_carry;
    logic        br_neg;

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            pcl_q   <= RST_VAL[7:0];
            pch_q   <= RST_VAL[15:8];
            adj_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            pcl_q   <= pcl_d;
            pch_q   <= pch_d;
            adj_q   <= adj_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pcl_d    = pcl_q;
        pch_d    = pch_q;
        adj_d    = adj_q;
        br_sum   = {1'b0, pcl_q} + {1'b0, DIN};
        br_carry = br_sum[8];
        br_neg   = DIN[7];
        case (state_q)
            IDLE: begin
                if (BR) begin
                    pcl_d = br_sum[7:0];
                    // Carry without a negative offset, or a negative offset without
                    // carry, means the target lives on the neighbouring page.
                    if (br_carry && !br_neg) begin
                        adj_d   = 8'h01;
                        state_d = FIX;
                    end else if (!br_carry && br_neg) begin
                        adj_d   = 8'hFF;
                        state_d = FIX;
                    end
                end else if (LDL || LDH) begin
                    if (LDL) pcl_d = DIN;
                    if (LDH) pch_d = DIN;
                end else if (INC) begin
                    {pch_d, pcl_d} = {pch_q, pcl_q} + 16'h0001;
                end
            end
            FIX: begin
                pch_d   = pch_q + adj_q;
                adj_d   = 8'h00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ADDR  = {pch_q, pcl_q};
    assign BUSY  = (state_q == FIX);
    assign PAGEX = (state_q == FIX);
    assign DOUT  = OEL ? pcl_q : (OEH ? pch_q : 8'h00);

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed test-plan cases plus random command traffic,
// all checked against a PC/target-address model on every rising edge.
module tb_program_counter;

    localparam logic [15:0] RST_VAL = 16'h0000;

    logic        CLK = 1'b1;
    logic        RST;
    logic        INC = 1'b0, LDL = 1'b0, LDH = 1'b0, BR = 1'b0;
    logic [7:0]  DIN = 8'h00;
    logic        OEL = 1'b0, OEH = 1'b0;
    logic [15:0] ADDR;
    logic [7:0]  DOUT;
    logic        BUSY, PAGEX;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit saw_busy;

    program_counter #(.RST_VAL(RST_VAL)) dut (
        .CLK(CLK), .RST(RST), .INC(INC), .LDL(LDL), .LDH(LDH), .BR(BR),
        .DIN(DIN), .OEL(OEL), .OEH(OEH),
        .ADDR(ADDR), .DOUT(DOUT), .BUSY(BUSY), .PAGEX(PAGEX)
    );

    always #5 CLK = ~CLK;

    // Model: PC as a 16-bit number; a branch computes its full target and, if
    // that target is on another page, shows the wrong-page address for one cycle.
    logic [15:0] m_pc, m_tgt, m_t;
    logic        m_busy;

    always @(negedge CLK or posedge RST) begin
        if (RST) begin
            m_pc   <= RST_VAL;
            m_busy <= 1'b0;
            m_tgt  <= 16'h0000;
        end else if (m_busy) begin
            m_pc   <= m_tgt;
            m_busy <= 1'b0;
        end else if (BR) begin
            m_t = m_pc + {{8{DIN[7]}}, DIN};
            if (m_t[15:8] != m_pc[15:8]) begin
                m_pc   <= {m_pc[15:8], m_t[7:0]};
                m_tgt  <= m_t;
                m_busy <= 1'b1;
            end else begin
                m_pc <= m_t;
            end
        end else if (LDL || LDH) begin
            m_pc <= {LDH ? DIN : m_pc[15:8], LDL ? DIN : m_pc[7:0]};
        end else if (INC) begin
            m_pc <= m_pc + 16'd1;
        end
    end

    function automatic logic [7:0] exp_dout(logic oel, logic oeh, logic [15:0] pc);
        if (oel) return pc[7:0];
        if (oeh) return pc[15:8];
        return 8'h00;
    endfunction

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (chk_en) begin
            chk("model_addr",  ADDR,  m_pc);
            chk("model_busy",  {15'd0, BUSY},  {15'd0, m_busy});
            chk("model_pagex", {15'd0, PAGEX}, {15'd0, m_busy});
            chk("model_dout",  {8'd0, DOUT},   {8'd0, exp_dout(OEL, OEH, m_pc)});
        end
    end

    // One falling edge with the given command; returns at the following rising edge.
    task automatic step(logic inc, logic ldl, logic ldh, logic br, logic [7:0] din,
                        logic oel = 1'b0, logic oeh = 1'b0);
        #1;
        INC = inc; LDL = ldl; LDH = ldh; BR = br; DIN = din; OEL = oel; OEH = oeh;
        @(posedge CLK);
        if (BUSY) saw_busy = 1'b1;
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 8'h00);
    endtask

    task automatic set_pc(logic [15:0] v);
        step(0, 1, 0, 0, v[7:0]);
        step(0, 0, 1, 0, v[15:8]);
    endtask

    initial begin
        RST = 1'b1;
        #2 chk_en = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        chk("reset_addr", ADDR, RST_VAL);
        chk("reset_busy", {15'd0, BUSY}, 16'd0);
        chk("reset_dout", {8'd0, DOUT}, 16'h0000);
        #1 RST = 1'b0;
        @(posedge CLK);

        step(1, 0, 0, 0, 8'h00); chk("inc1", ADDR, 16'h0001);
        step(1, 0, 0, 0, 8'h00); chk("inc2", ADDR, 16'h0002);
        step(1, 0, 0, 0, 8'h00); chk("inc3", ADDR, 16'h0003);
        set_pc(16'hFFFF);
        step(1, 0, 0, 0, 8'h00); chk("inc_wrap", ADDR, 16'h0000);

        step(0, 1, 0, 0, 8'h34);
        step(0, 0, 1, 0, 8'h12); chk("load_1234", ADDR, 16'h1234);
        step(0, 1, 1, 0, 8'hAB); chk("load_both", ADDR, 16'hABAB);
        step(1, 1, 0, 0, 8'h56); chk("load_over_inc", ADDR, 16'hAB56);

        set_pc(16'h1210);
        saw_busy = 1'b0;
        step(0, 0, 0, 1, 8'h05); chk("br_nocross", ADDR, 16'h1215);
        nop();
        chk("br_nocross_busy", {15'd0, saw_busy}, 16'd0);

        set_pc(16'h12F0);
        step(0, 0, 0, 1, 8'h20);
        chk("fwd_e1_addr", ADDR, 16'h1210);
        chk("fwd_e1_busy", {14'd0, BUSY, PAGEX}, 16'h0003);
        step(1, 0, 0, 0, 8'h00);
        chk("fwd_e2_addr", ADDR, 16'h1310);
        chk("fwd_e2_busy", {14'd0, BUSY, PAGEX}, 16'h0000);

        set_pc(16'h0005);
        step(0, 0, 0, 1, 8'hF0); chk("bwd_e1", ADDR, 16'h00F5);
        nop();                   chk("bwd_e2", ADDR, 16'hFFF5);

        set_pc(16'h0005);
        step(0, 0, 0, 1, 8'hF0); chk("rst_fix_pre", {15'd0, BUSY}, 16'd1);
        #1;
        BR = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_fix_addr", ADDR, RST_VAL);
        chk("rst_fix_busy", {14'd0, BUSY, PAGEX}, 16'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        nop(); nop();
        chk("rst_fix_noadj", ADDR, RST_VAL);

        set_pc(16'h1234);
        step(0, 0, 0, 0, 8'h00, 1, 0); chk("dout_oel",  {8'd0, DOUT}, 16'h0034);
        step(0, 0, 0, 0, 8'h00, 0, 1); chk("dout_oeh",  {8'd0, DOUT}, 16'h0012);
        step(0, 0, 0, 0, 8'h00, 1, 1); chk("dout_both", {8'd0, DOUT}, 16'h0034);
        step(0, 0, 0, 0, 8'h00, 0, 0); chk("dout_none", {8'd0, DOUT}, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #1 RST = 1'b1;
                @(posedge CLK);
                #1 RST = 1'b0;
                @(posedge CLK);
            end else begin
                step($urandom_range(0, 1), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                     8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
            end
        end

        #1;
        INC = 0; LDL = 0; LDH = 0; BR = 0;
        @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_counter.md
# program_counter

16-bit 65C02 program counter stage: holds PCL/PCH, drives the address bus, and feeds either PC byte onto the internal data bus for stack pushes (JSR/BRK/IRQ). It consumes bytes from the same data bus that loads the 8-bit working registers. It implements single-cycle increment, byte loads for jumps and vector fetches, and relative branches with the 65C02 page-cross fix-up cycle.

## Interface
- RST_VAL, 16'h0000: PC value on reset; the vector fetch is sequenced externally.
- CLK  in  1  system clock; all state changes on the falling edge.
- RST  in  1  reset, asynchronous, active-high.
- INC  in  1  increment PC by 1.
- LDL  in  1  load PCL from DIN.
- LDH  in  1  load PCH from DIN.
- BR  in  1  start relative branch; DIN holds the signed 8-bit offset.
- DIN  in  8  internal data bus input.
- OEL  in  1  drive PCL on DOUT.
- OEH  in  1  drive PCH on DOUT.
- ADDR  out  16  current PC, {PCH, PCL}, registered.
- DOUT  out  8  PCL if OEL; else PCH if OEH; else 8'h00. Combinational.
- BUSY  out  1  high during the fix-up cycle, registered.
- PAGEX  out  1  one-cycle pulse, high during the fix-up cycle. Identical to BUSY; kept separate for the cycle counter.

## Operation
- States: IDLE and FIX. Reset state is IDLE.
- Command priority in IDLE (one action per edge): BR > load > INC.
  - Load means LDL and/or LDH. Both may be asserted together; both halves then take DIN.
  - INC is ignored in a cycle where BR or a load is taken.
- INC: PC <= PC + 1, modulo 2^16. 16'hFFFF wraps to 16'h0000 in one cycle.
- BR, first edge:
  - {c, PCL} <= PCL + DIN (9-bit sum); s = DIN[7].
  - adj = +1 if c & ~s; -1 if ~c & s; else 0.
  - adj != 0: latch adj, go to FIX.
  - adj == 0: stay in IDLE; the branch is complete.
- FIX: PCH <= PCH + adj (8-bit, wraps 8'hFF<->8'h00, so PC wraps modulo 2^16), then return to IDLE.
  - During FIX, ADDR shows the intermediate wrong-page address, matching the 65C02 dummy read.
  - All commands (INC, LDL, LDH, BR) are ignored while in FIX.
- DOUT is independent of state; OEL takes priority over OEH.
- RST asserted at any time, including mid-FIX: PC = RST_VAL, state = IDLE, BUSY = 0, PAGEX = 0, and the latched adj is cleared.

## Timing
- Reset values: ADDR = RST_VAL, BUSY = 0, PAGEX = 0, DOUT = 8'h00 (with OEL = OEH = 0).
- INC and loads: ADDR updates on the same falling edge that samples the command. Latency is 1 edge.
- Branch without page cross: 1 edge, BUSY stays 0.
- Branch with page cross:
  - Edge 1: PCL updates; BUSY and PAGEX rise.
  - Edge 2: PCH updates; BUSY and PAGEX fall.
  - Total latency is 2 edges.
- Controller rule: the sequencer must hold off commands while BUSY = 1. Commands issued during FIX are dropped, not queued.
- RST deassertion takes effect at the next falling edge. No command is sampled on the edge where RST is high.

## Test plan
- Reset and increment: RST pulse with RST_VAL = 16'h0000, then 3 INC edges. Required: ADDR = 0000 during reset, then 0001, 0002, 0003. Start from 16'hFFFF and INC: required ADDR = 0000.
- Byte loads: DIN = 8'h34 with LDL, then DIN = 8'h12 with LDH. Required: ADDR = 16'h1234. LDL and LDH together with DIN = 8'hAB: required ADDR = 16'hABAB. LDL + INC in the same cycle: required load only.
- Branch, no page cross: PC = 16'h1210, BR with DIN = 8'h05. Required: ADDR = 16'h1215 after 1 edge, BUSY never high.
- Forward page cross: PC = 16'h12F0, BR with DIN = 8'h20. Required: ADDR = 16'h1210 with BUSY = PAGEX = 1 on edge 1, then ADDR = 16'h1310 with BUSY = 0 on edge 2. An INC during FIX is ignored.
- Backward page cross and wrap: PC = 16'h0005, BR with DIN = 8'hF0 (-16). Required: ADDR = 16'h00F5 on edge 1, then 16'hFFF5 on edge 2.
- Reset mid-FIX and DOUT muxing:
  - Assert RST during FIX of the previous case. Required: ADDR = RST_VAL immediately (asynchronous), BUSY = 0, and no residual PCH adjust after release.
  - With PC = 16'h1234: OEL gives DOUT = 8'h34; OEH gives 8'h12; both give 8'h34; neither gives 8'h00.
